// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues one-at-a-time imem reads and
// buffers {pc, inst} pairs for decode. Define IFETCH_PERF_EN to add perf counters.
module inst_fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 64
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic [PC_W-1:0] startPC,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_out,
  output logic [PC_W-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushed
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic              imem_req_q, imem_req_d;
  logic [PC_W-1:0]   imem_addr_q, imem_addr_d;
  logic              push;
  logic              pop;

  logic [PC_W-1:0]   pc_mem_q   [DEPTH];
  logic [31:0]       inst_mem_q [DEPTH];

  // Next-state: redirect overrides everything, including a same-cycle pop.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    push        = 1'b0;
    pop         = 1'b0;
    imem_req_d  = 1'b0;
    imem_addr_d = imem_addr_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ALIGN_MASK;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_WAIT:  state_d = imem_ack ? S_IDLE : S_DROP;
        S_DROP:  state_d = imem_ack ? S_IDLE : S_DROP;
        default: state_d = S_IDLE;
      endcase
    end else begin
      pop = inst_valid && inst_ready;
      case (state_q)
        S_IDLE: begin
          if (count_q < CNT_W'(DEPTH)) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_ack) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_W'(4);
          end
        end
        S_DROP: begin
          if (imem_ack) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (push) state_d = (count_d < CNT_W'(DEPTH)) ? S_WAIT : S_IDLE;
    end

    // The dropped request keeps its original address until its ack arrives.
    imem_req_d  = (state_d != S_IDLE);
    imem_addr_d = (state_d == S_DROP) ? imem_addr_q : fetch_pc_d;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= startPC & ALIGN_MASK;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= startPC & ALIGN_MASK;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
    end
  end

  // FIFO storage needs no reset; count gates visibility.
  always_ff @(posedge CLK) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
      inst_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign inst_valid = (count_q != '0);
  assign inst_out   = inst_valid ? inst_mem_q[rd_ptr_q] : 32'd0;
  assign inst_pc    = inst_valid ? pc_mem_q[rd_ptr_q] : '0;

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;
  logic        drop_ack;
  logic [32:0] flushed_sum;

  // Saturating counters; an ack whose data is thrown away counts as one flushed.
  always_comb begin
    drop_ack       = imem_ack && (((state_q == S_WAIT) && redirect_valid) || (state_q == S_DROP));
    perf_fetched_d = perf_fetched_q;
    if (push && (perf_fetched_q != 32'hFFFF_FFFF)) perf_fetched_d = perf_fetched_q + 32'd1;
    flushed_sum    = {1'b0, perf_flushed_q}
                   + (redirect_valid ? 33'(count_q) : 33'd0)
                   + 33'(drop_ack);
    perf_flushed_d = flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue (DEPTH=4, PC_W=64).
module tb_inst_fetch_queue;

  localparam int unsigned PC_W = 64;

  logic            CLK = 1'b0;
  logic            Reset = 1'b0;
  logic [PC_W-1:0] startPC = '0;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack = 1'b0;
  logic [31:0]     imem_rdata = '0;
  logic            inst_valid;
  logic            inst_ready = 1'b0;
  logic [31:0]     inst_out;
  logic [PC_W-1:0] inst_pc;
  logic            redirect_valid = 1'b0;
  logic [PC_W-1:0] redirect_pc = '0;
`ifdef IFETCH_PERF_EN
  logic [31:0]     perf_fetched;
  logic [31:0]     perf_flushed;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Memory responder / consumer model state
  bit              resp_en  = 1'b0;
  int              ack_lat  = 0;
  int              wait_cnt = 0;
  bit              acked    = 1'b0;
  logic [PC_W-1:0] ack_addr = '0;
  bit              chk_pop  = 1'b0;
  logic [PC_W-1:0] exp_pc   = '0;
  int              n_pops   = 0;

  inst_fetch_queue #(.DEPTH(4), .PC_W(PC_W)) dut (
    .CLK            (CLK),
    .Reset          (Reset),
    .startPC        (startPC),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: memory model decides ack, consumer checks a pop, then edge + 1.
  task automatic tick();
    acked = 1'b0;
    if (resp_en) begin
      imem_ack = 1'b0;
      if (imem_req && !Reset) begin
        if (wait_cnt == ack_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          ack_addr   = imem_addr;
          wait_cnt   = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
    if (imem_ack) acked = 1'b1;
    if (chk_pop && inst_valid && inst_ready && !redirect_valid) begin
      check_eq("pop_pc", inst_pc, exp_pc);
      check_eq("pop_inst", 64'(inst_out), 64'(mem_word(exp_pc)));
      exp_pc = exp_pc + 64'd4;
      n_pops++;
    end
    @(posedge CLK);
    #1;
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset(input logic [PC_W-1:0] pc);
    chk_pop        = 1'b0;
    resp_en        = 1'b1;
    wait_cnt       = 0;
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
    startPC        = pc;
    Reset          = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    int n_acks;
    int t;
    #1;

    // Test 1: reset state, then ack 2 cycles after each request with decode ready
    inst_ready = 1'b1;
    ack_lat    = 2;
    do_reset(64'h1000);
    check_eq("rst_req", 64'(imem_req), 64'd0);
    check_eq("rst_addr", imem_addr, 64'h1000);
    check_eq("rst_valid", 64'(inst_valid), 64'd0);
    check_eq("rst_inst", 64'(inst_out), 64'd0);
    check_eq("rst_pc", inst_pc, 64'd0);
    Reset = 1'b0;
    tick();
    check_eq("t1_first_req", 64'(imem_req), 64'd1);
    check_eq("t1_first_addr", imem_addr, 64'h1000);
    for (int k = 0; k < 3; k++) begin
      t = 0;
      do begin
        tick();
        t++;
      end while (!acked && t < 20);
      check_eq("t1_ack_seen", 64'(acked), 64'd1);
      if (k > 0) check_eq("t1_ack_gap", 64'(t), 64'd3);
      check_eq("t1_ack_addr", ack_addr, 64'h1000 + 64'(4 * k));
      check_eq("t1_valid", 64'(inst_valid), 64'd1);
      check_eq("t1_inst_pc", inst_pc, 64'h1000 + 64'(4 * k));
      check_eq("t1_inst_out", 64'(inst_out), 64'(mem_word(64'h1000 + 64'(4 * k))));
      check_eq("t1_next_addr", imem_addr, 64'h1004 + 64'(4 * k));
    end

    // Test 2: decode stalled, zero-wait memory fills the FIFO then stops
    inst_ready = 1'b0;
    ack_lat    = 0;
    do_reset(64'h1000);
    Reset  = 1'b0;
    n_acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (acked) n_acks++;
    end
    check_eq("t2_acks", 64'(n_acks), 64'd4);
    check_eq("t2_req_off", 64'(imem_req), 64'd0);
    check_eq("t2_valid", 64'(inst_valid), 64'd1);
    check_eq("t2_head_pc", inst_pc, 64'h1000);
    check_eq("t2_head_inst", 64'(inst_out), 64'(mem_word(64'h1000)));
    inst_ready = 1'b1;
    chk_pop    = 1'b1;
    exp_pc     = 64'h1000;
    t = 0;
    while (!imem_req && t < 10) begin
      tick();
      t++;
    end
    check_eq("t2_resume_req", 64'(imem_req), 64'd1);
    check_eq("t2_resume_addr", imem_addr, 64'h1010);
    for (int i = 0; i < 6; i++) tick();

    // Test 3: redirect with 3 queued entries and an outstanding request
    inst_ready = 1'b0;
    ack_lat    = 0;
    do_reset(64'h1000);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    resp_en = 1'b0;
    check_eq("t3_pre_valid", 64'(inst_valid), 64'd1);
    check_eq("t3_pre_req", 64'(imem_req), 64'd1);
    check_eq("t3_pre_addr", imem_addr, 64'h100C);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h2003;
    tick();
    check_eq("t3_flush_valid", 64'(inst_valid), 64'd0);
    check_eq("t3_flush_inst", 64'(inst_out), 64'd0);
    check_eq("t3_drop_req", 64'(imem_req), 64'd1);
    check_eq("t3_drop_addr", imem_addr, 64'h100C);
    tick();
    tick();
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    tick();
    check_eq("t3_late_valid", 64'(inst_valid), 64'd0);
    check_eq("t3_late_req", 64'(imem_req), 64'd0);
    resp_en    = 1'b1;
    wait_cnt   = 0;
    inst_ready = 1'b1;
    chk_pop    = 1'b1;
    exp_pc     = 64'h2000;
    n_pops     = 0;
    tick();
    check_eq("t3_new_req", 64'(imem_req), 64'd1);
    check_eq("t3_new_addr", imem_addr, 64'h2000);
    for (int i = 0; i < 8; i++) tick();
    check_eq("t3_pops", 64'(n_pops), 64'd7);

    // Test 4: redirect coincident with ack and pop
    inst_ready = 1'b0;
    ack_lat    = 0;
    do_reset(64'h1000);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    resp_en = 1'b0;
    check_eq("t4_pre_valid", 64'(inst_valid), 64'd1);
    check_eq("t4_pre_pc", inst_pc, 64'h1000);
    imem_ack       = 1'b1;
    imem_rdata     = 32'h1234_5678;
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3000;
    tick();
    check_eq("t4_valid", 64'(inst_valid), 64'd0);
    check_eq("t4_req", 64'(imem_req), 64'd0);
    resp_en  = 1'b1;
    wait_cnt = 0;
    chk_pop  = 1'b1;
    exp_pc   = 64'h3000;
    n_pops   = 0;
    tick();
    check_eq("t4_new_req", 64'(imem_req), 64'd1);
    check_eq("t4_new_addr", imem_addr, 64'h3000);
    for (int i = 0; i < 4; i++) tick();
    check_eq("t4_pops", 64'(n_pops), 64'd3);

    // Test 5: PC increment wraps at the top of the address space
    inst_ready = 1'b1;
    ack_lat    = 0;
    do_reset(64'hFFFF_FFFF_FFFF_FFFC);
    Reset   = 1'b0;
    chk_pop = 1'b1;
    exp_pc  = 64'hFFFF_FFFF_FFFF_FFFC;
    n_pops  = 0;
    tick();
    check_eq("t5_addr0", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    check_eq("t5_addr1", imem_addr, 64'h0);
    tick();
    tick();
    check_eq("t5_pops", 64'(n_pops), 64'd2);

    // Test 6: asynchronous reset while waiting with 2 entries queued
    inst_ready = 1'b0;
    ack_lat    = 0;
    do_reset(64'h1000);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    resp_en = 1'b0;
    check_eq("t6_pre_valid", 64'(inst_valid), 64'd1);
    check_eq("t6_pre_req", 64'(imem_req), 64'd1);
    startPC = 64'h4000;
    Reset   = 1'b1;
    #1;
    check_eq("t6_rst_req", 64'(imem_req), 64'd0);
    check_eq("t6_rst_valid", 64'(inst_valid), 64'd0);
    check_eq("t6_rst_inst", 64'(inst_out), 64'd0);
    check_eq("t6_rst_pc", inst_pc, 64'd0);
    check_eq("t6_rst_addr", imem_addr, 64'h4000);
`ifdef IFETCH_PERF_EN
    check_eq("t6_perf_fetched", 64'(perf_fetched), 64'd0);
    check_eq("t6_perf_flushed", 64'(perf_flushed), 64'd0);
`endif
    tick();
    tick();
    Reset    = 1'b0;
    resp_en  = 1'b1;
    wait_cnt = 0;
    tick();
    check_eq("t6_restart_req", 64'(imem_req), 64'd1);
    check_eq("t6_restart_addr", imem_addr, 64'h4000);
    tick();
    check_eq("t6_restart_valid", 64'(inst_valid), 64'd1);
    check_eq("t6_restart_pc", inst_pc, 64'h4000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
